fsub_norm_pipe: RTL and testbench



---
 rtl/fsub_norm_pipe_if.sv | 31 +++
 rtl/fsub_norm_pipe.sv | 106 ++++++++++
 tb/tb_fsub_norm_pipe.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsub_norm_pipe_if.sv
// Valid/ready bundle between the FSUB subtract/LZA stage, the normalizer and the rounder.
// The slave modport is the normalizer's view; master is the surrounding datapath's view.
interface fsub_norm_pipe_if #(
    parameter int MANT_W = 34,
    parameter int EXP_W  = 10
);
    logic              i_valid;
    logic              o_ready;
    logic [MANT_W-1:0] i_mag;
    logic [5:0]        i_lza_num;
    logic              i_correct;
    logic [EXP_W-1:0]  i_exp;
    logic              i_sign;
    logic              o_valid;
    logic              i_ready;
    logic [MANT_W-1:0] o_mant;
    logic [EXP_W-1:0]  o_exp;
    logic              o_sign;
    logic              o_zero;
    logic              o_uf;

    modport slave (
        input  i_valid, i_mag, i_lza_num, i_correct, i_exp, i_sign, i_ready,
        output o_ready, o_valid, o_mant, o_exp, o_sign, o_zero, o_uf
    );

    modport master (
        output i_valid, i_mag, i_lza_num, i_correct, i_exp, i_sign, i_ready,
        input  o_ready, o_valid, o_mant, o_exp, o_sign, o_zero, o_uf
    );
endinterface

// File: rtl/fsub_norm_pipe.sv
// Two-stage elastic normalizer: shifts the FSUB difference magnitude by the LZA count,
// adjusts the exponent and flags zero / underflow results.
module fsub_norm_pipe #(
    parameter int MANT_W = 34,
    parameter int EXP_W  = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fsub_norm_pipe_if.slave    bus
);
    localparam logic [5:0] L_MANT_W6 = 6'(MANT_W);
    localparam logic [6:0] L_MANT_W7 = 7'(MANT_W);

    logic              r_s1Valid;
    logic [6:0]        r_s1Amt;
    logic [MANT_W-1:0] r_s1MagShl;
    logic              r_s1Correct;
    logic [EXP_W-1:0]  r_s1Exp;
    logic              r_s1Sign;
    logic              r_s1Zero;

    logic              r_s2Valid;
    logic [MANT_W-1:0] r_s2Mant;
    logic [EXP_W-1:0]  r_s2Exp;
    logic              r_s2Sign;
    logic              r_s2Zero;
    logic              r_s2Uf;

    logic [6:0]        w_amt;
    logic [MANT_W-1:0] w_magShl;
    logic [MANT_W-1:0] w_mant;
    logic [EXP_W:0]    w_expTmp;
    logic              w_uf;
    logic              w_s2Advance;

    assign w_s2Advance = ~r_s2Valid | bus.i_ready;
    assign bus.o_ready = ~r_s1Valid | w_s2Advance;

    always_comb begin
        w_amt    = {1'b0, bus.i_lza_num} + {6'd0, bus.i_correct};
        w_magShl = '0;
        if (bus.i_lza_num < L_MANT_W6) begin
            w_magShl = bus.i_mag << bus.i_lza_num;
        end
    end

    // The extra bit of w_expTmp acts as the borrow; a borrow or an exact zero both mean underflow.
    always_comb begin
        w_mant = '0;
        if (r_s1Amt < L_MANT_W7) begin
            w_mant = r_s1Correct ? (r_s1MagShl << 1) : r_s1MagShl;
        end
        w_expTmp = {1'b0, r_s1Exp} - (EXP_W+1)'(r_s1Amt);
        w_uf     = ~r_s1Zero & (w_expTmp[EXP_W] | (w_expTmp == '0));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1Valid   <= 1'b0;
            r_s1Amt     <= '0;
            r_s1MagShl  <= '0;
            r_s1Correct <= 1'b0;
            r_s1Exp     <= '0;
            r_s1Sign    <= 1'b0;
            r_s1Zero    <= 1'b0;
        end else if (bus.o_ready) begin
            r_s1Valid <= bus.i_valid;
            if (bus.i_valid) begin
                r_s1Amt     <= w_amt;
                r_s1MagShl  <= w_magShl;
                r_s1Correct <= bus.i_correct;
                r_s1Exp     <= bus.i_exp;
                r_s1Sign    <= bus.i_sign;
                r_s1Zero    <= (bus.i_mag == '0);
            end
        end
    end

    // Stage-2 registers drive the outputs directly, so they stay frozen while downstream stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2Valid <= 1'b0;
            r_s2Mant  <= '0;
            r_s2Exp   <= '0;
            r_s2Sign  <= 1'b0;
            r_s2Zero  <= 1'b0;
            r_s2Uf    <= 1'b0;
        end else if (w_s2Advance) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Mant <= r_s1Zero ? '0 : w_mant;
                r_s2Exp  <= (r_s1Zero | w_uf) ? '0 : w_expTmp[EXP_W-1:0];
                r_s2Sign <= r_s1Sign & ~r_s1Zero;
                r_s2Zero <= r_s1Zero;
                r_s2Uf   <= w_uf;
            end
        end
    end

    assign bus.o_valid = r_s2Valid;
    assign bus.o_mant  = r_s2Mant;
    assign bus.o_exp   = r_s2Exp;
    assign bus.o_sign  = r_s2Sign;
    assign bus.o_zero  = r_s2Zero;
    assign bus.o_uf    = r_s2Uf;
endmodule

// File: tb/tb_fsub_norm_pipe.sv
// Self-checking bench for fsub_norm_pipe: directed cases, backpressure, random streams and
// asynchronous reset, checked against an arithmetic reference model.
module tb_fsub_norm_pipe;
    localparam int MW = 34;
    localparam int EW = 10;

    typedef struct packed {
        logic [MW-1:0] mag;
        logic [5:0]    lza;
        logic          corr;
        logic [EW-1:0] exp;
        logic          sign;
    } beat_t;

    typedef struct packed {
        logic [MW-1:0] mant;
        logic [EW-1:0] exp;
        logic          sign;
        logic          zero;
        logic          uf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    fsub_norm_pipe_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

    fsub_norm_pipe #(.MANT_W(MW), .EXP_W(EW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Normalization as plain arithmetic: shift by the full count, subtract it from the exponent.
    function automatic res_t refModel(input beat_t b);
        res_t        r;
        int          amt;
        int          e;
        logic [63:0] wide;
        r   = '0;
        amt = int'(b.lza) + int'(b.corr);
        if (b.mag == '0) begin
            r.zero = 1'b1;
            return r;
        end
        wide   = (amt >= MW) ? 64'd0 : (64'(b.mag) << amt);
        r.mant = wide[MW-1:0];
        r.sign = b.sign;
        e      = int'(b.exp) - amt;
        if (e <= 0) begin
            r.uf  = 1'b1;
            r.exp = '0;
        end else begin
            r.exp = e[EW-1:0];
        end
        return r;
    endfunction

    // Random operand honouring the LZA contract: the count is exact or one short with i_correct set.
    function automatic beat_t randBeat();
        beat_t       b;
        int          pos;
        logic [63:0] rnd;
        b.sign = 1'($urandom_range(0, 1));
        b.exp  = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(0, 40)) : EW'($urandom_range(0, 1023));
        b.corr = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
            b.mag  = '0;
            b.lza  = 6'($urandom_range(0, 63));
            b.corr = 1'($urandom_range(0, 1));
        end else begin
            pos   = $urandom_range(0, MW-1);
            rnd   = {$urandom, $urandom};
            rnd   = (rnd & ((64'd1 << pos) - 64'd1)) | (64'd1 << pos);
            b.mag = rnd[MW-1:0];
            b.lza = 6'(MW - 1 - pos);
            if (b.lza != 6'd0 && $urandom_range(0, 1) == 1) begin
                b.lza  = b.lza - 6'd1;
                b.corr = 1'b1;
            end
        end
        return b;
    endfunction

    task automatic setInputs(input beat_t b);
        bus.i_mag     = b.mag;
        bus.i_lza_num = b.lza;
        bus.i_correct = b.corr;
        bus.i_exp     = b.exp;
        bus.i_sign    = b.sign;
    endtask

    function automatic res_t observed();
        return {bus.o_mant, bus.o_exp, bus.o_sign, bus.o_zero, bus.o_uf};
    endfunction

    task automatic test_reset();
        res_t got;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        setInputs('0);
        repeat (2) @(negedge clk);
        got = observed();
        total++;
        if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", bus.o_valid); end
        total++;
        if (bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", bus.o_ready); end
        total++;
        if (got !== res_t'(0)) begin bad++; $display("[TB] FAIL reset_data got=%h want=0", got); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed(input string name, input beat_t b, input res_t want);
        res_t got;
        @(negedge clk);
        setInputs(b);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        total++;
        if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s_early got=%b want=0", name, bus.o_valid); end
        @(negedge clk);
        got = observed();
        total++;
        if (bus.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL %s_valid got=%b want=1", name, bus.o_valid); end
        total++;
        if (got !== want) begin bad++; $display("[TB] FAIL %s_data got=%h want=%h", name, got, want); end
        @(negedge clk);
        total++;
        if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s_dup got=%b want=0", name, bus.o_valid); end
    endtask

    task automatic test_backpressure();
        beat_t b[4];
        res_t  e[4];
        res_t  got;
        int    sent = 0;
        int    recv = 0;
        for (int k = 0; k < 4; k++) begin
            b[k].mag  = 34'h1_0000_0000 | 34'(k);
            b[k].lza  = 6'd1;
            b[k].corr = 1'b0;
            b[k].exp  = EW'(10 + k);
            b[k].sign = k[0];
            e[k]      = refModel(b[k]);
        end
        for (int c = 0; c < 40 && recv < 4; c++) begin
            @(negedge clk);
            bus.i_ready = (c >= 8);
            bus.i_valid = (sent < 4);
            if (sent < 4) setInputs(b[sent]);
            #1;
            got = observed();
            if (c == 7) begin
                total++;
                if (sent !== 2) begin bad++; $display("[TB] FAIL bp_accepted got=%0d want=2", sent); end
                total++;
                if (bus.o_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready got=%b want=0", bus.o_ready); end
            end
            if (c >= 2 && c < 8) begin
                total++;
                if (bus.o_valid !== 1'b1 || got !== e[0]) begin
                    bad++;
                    $display("[TB] FAIL bp_hold cycle=%0d valid=%b got=%h want=%h", c, bus.o_valid, got, e[0]);
                end
            end
            if (bus.o_valid && bus.i_ready) begin
                total++;
                if (got !== e[recv]) begin bad++; $display("[TB] FAIL bp_order idx=%0d got=%h want=%h", recv, got, e[recv]); end
                recv++;
            end
            if (bus.i_valid && bus.o_ready) sent++;
        end
        bus.i_valid = 1'b0;
        total++;
        if (recv !== 4) begin bad++; $display("[TB] FAIL bp_count got=%0d want=4", recv); end
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_extra got=%b want=0", bus.o_valid); end
        end
    endtask

    task automatic test_stream(input int n, input bit stall);
        res_t  expq[$];
        res_t  got;
        res_t  want;
        beat_t cur;
        int    sent = 0;
        int    recv = 0;
        int    firstCyc = -1;
        int    lastCyc = -1;
        cur = randBeat();
        for (int c = 0; c < 20*n + 50 && recv < n; c++) begin
            @(negedge clk);
            bus.i_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.i_valid = (sent < n) && (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
            setInputs(cur);
            #1;
            if (bus.o_valid && bus.i_ready) begin
                got = observed();
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL stream_extra got=%h want=none", got);
                end else begin
                    want = expq.pop_front();
                    if (got !== want) begin bad++; $display("[TB] FAIL stream_data idx=%0d got=%h want=%h", recv, got, want); end
                end
                if (!got.zero) begin
                    total++;
                    if (got.mant[MW-1] !== 1'b1) begin bad++; $display("[TB] FAIL stream_msb got=%h want=msb set", got.mant); end
                end
                if (firstCyc < 0) firstCyc = c;
                lastCyc = c;
                recv++;
            end
            if (bus.i_valid && bus.o_ready) begin
                expq.push_back(refModel(cur));
                sent++;
                cur = randBeat();
            end
        end
        bus.i_valid = 1'b0;
        total++;
        if (recv !== n) begin bad++; $display("[TB] FAIL stream_count got=%0d want=%0d", recv, n); end
        if (!stall) begin
            total++;
            if (lastCyc - firstCyc !== n - 1) begin
                bad++;
                $display("[TB] FAIL stream_gapless got=%0d want=%0d", lastCyc - firstCyc, n - 1);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        setInputs(beat_t'{34'h2_0000_0000, 6'd0, 1'b0, 10'd300, 1'b1});
        @(negedge clk);
        setInputs(beat_t'{34'h1_0000_0000, 6'd1, 1'b0, 10'd301, 1'b0});
        @(posedge clk);
        #2;
        bus.i_valid = 1'b0;
        total++;
        if (bus.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL ar_inflight got=%b want=1", bus.o_valid); end
        rst = 1'b1;
        #1;
        total++;
        if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL ar_valid got=%b want=0", bus.o_valid); end
        total++;
        if (bus.o_ready !== 1'b1) begin bad++; $display("[TB] FAIL ar_ready got=%b want=1", bus.o_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            total++;
            if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL ar_stale got=%b want=0", bus.o_valid); end
        end
    endtask

    initial begin
        $display("[TB] starting fsub_norm_pipe bench");
        test_reset();
        test_directed("basic", beat_t'{34'h0_8000_0000, 6'd2, 1'b0, 10'd100, 1'b1},
                      res_t'{34'h2_0000_0000, 10'd98, 1'b1, 1'b0, 1'b0});
        test_directed("correct", beat_t'{34'h0_8000_0000, 6'd1, 1'b1, 10'd100, 1'b0},
                      res_t'{34'h2_0000_0000, 10'd98, 1'b0, 1'b0, 1'b0});
        test_directed("zero", beat_t'{34'h0, 6'd33, 1'b0, 10'd57, 1'b1},
                      res_t'{34'h0, 10'd0, 1'b0, 1'b1, 1'b0});
        test_directed("underflow", beat_t'{34'h0_0000_0400, 6'd23, 1'b0, 10'd5, 1'b1},
                      res_t'{34'h2_0000_0000, 10'd0, 1'b1, 1'b0, 1'b1});
        test_directed("shift_limit", beat_t'{34'h0_0000_0001, 6'd33, 1'b1, 10'd100, 1'b0},
                      res_t'{34'h0, 10'd66, 1'b0, 1'b0, 1'b0});
        test_backpressure();
        test_stream(16, 1'b0);
        test_stream(200, 1'b1);
        test_async_reset();
        test_stream(16, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
